// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch (I) and load/store (D)
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int LAT          = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [3:0]        m_wstrb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [3:0] CNT_INIT   = 4'(LAT - 1);

    logic [1:0]        state;
    logic              owner;
    logic [3:0]        streak;
    logic [3:0]        cnt;
    logic              we_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              d_wins;

    // Address bits outside the memory window and the byte offset are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr, d_addr};

    // D wins unless it has starved a pending fetch for MAX_D_STREAK grants.
    always_comb begin
        d_wins = d_req && !(i_req && (streak == STREAK_MAX));
        d_gnt  = (state == S_IDLE) && d_wins;
        i_gnt  = (state == S_IDLE) && !d_wins && i_req;
    end

    assign m_en     = (state == S_ISSUE);
    assign m_we     = m_en && we_q;
    assign m_wstrb  = m_en ? wstrb_q : 4'b0000;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign i_rvalid = (state == S_RESP) && (owner == OWN_I);
    assign d_rvalid = (state == S_RESP) && (owner == OWN_D);
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

    // Transaction sequencer: latch on grant, strobe once, count latency, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= OWN_D;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            wstrb_q   <= 4'b0000;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (d_gnt) begin
                        owner   <= OWN_D;
                        addr_q  <= {d_addr[ADDR_W-1:2], 2'b00};
                        we_q    <= d_we;
                        wstrb_q <= d_wstrb;
                        wdata_q <= d_wdata;
                        state   <= S_ISSUE;
                    end else if (i_gnt) begin
                        owner   <= OWN_I;
                        addr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
                        we_q    <= 1'b0;
                        wstrb_q <= 4'b0000;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= CNT_INIT;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        if (owner == OWN_I) begin
                            i_rdata_q <= m_rdata;
                        end else begin
                            d_rdata_q <= we_q ? 32'd0 : m_rdata;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Consecutive-D counter, only moved on grant cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= 4'd0;
        end else if (d_gnt) begin
            if (!i_req) begin
                streak <= 4'd0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end
        end else if (i_gnt) begin
            streak <= 4'd0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LAT    = 2;
    localparam int MAXD   = 4;

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_wstrb;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              m_en;
    logic              m_we;
    logic [3:0]        m_wstrb;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    int vectors    = 0;
    int miscompares = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT), .MAX_D_STREAK(MAXD)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word array with byte-enabled writes, reads delivered LAT cycles after m_en.
    logic [31:0] mem [0:(1<<(ADDR_W-2))-1];
    logic [31:0] rd_pipe [0:LAT-1];
    logic        loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int w = 0; w < (1<<(ADDR_W-2)); w++) mem[w] <= 32'd0;
            mem[1]  <= 32'h0000_0093;
            mem[2]  <= 32'h1234_5678;
            loaded  <= 1'b1;
        end else if (m_en && m_we) begin
            for (int b = 0; b < 4; b++)
                if (m_wstrb[b]) mem[m_addr[ADDR_W-1:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
        if (m_en) rd_pipe[0] <= mem[m_addr[ADDR_W-1:2]];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign m_rdata = rd_pipe[LAT-1];

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we, m_wstrb, m_addr, m_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0",
                     {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we, m_wstrb, m_addr, m_wdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk); i_req = 1'b1; i_addr = 32'h0000_0004; #1;
        vectors++;
        if ({i_gnt, d_gnt} !== 2'b10) begin miscompares++; $display("FAIL fetch_gnt: got %b want 10", {i_gnt, d_gnt}); end
        @(negedge clk); i_req = 1'b0; #1;
        vectors++;
        if ({m_en, m_we, m_wstrb, m_addr} !== {1'b1, 1'b0, 4'b0000, 16'h0004}) begin
            miscompares++; $display("FAIL fetch_issue: got %h want %h", {m_en, m_we, m_wstrb, m_addr}, {1'b1, 1'b0, 4'b0000, 16'h0004});
        end
        repeat (LAT) begin
            @(negedge clk); #1;
            vectors++;
            if ({m_en, i_rvalid} !== 2'b00) begin miscompares++; $display("FAIL fetch_wait: got %b want 00", {m_en, i_rvalid}); end
        end
        @(negedge clk); #1;
        vectors++;
        if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 32'h0000_0093}) begin
            miscompares++; $display("FAIL fetch_resp: got %h want %h", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 32'h0000_0093});
        end
    endtask

    task automatic test_addr_wrap();
        @(negedge clk); i_req = 1'b1; i_addr = 32'hFFFF_0008; #1;
        vectors++;
        if ({i_gnt, d_gnt} !== 2'b10) begin miscompares++; $display("FAIL wrap_gnt: got %b want 10", {i_gnt, d_gnt}); end
        @(negedge clk); i_req = 1'b0; #1;
        vectors++;
        if ({m_en, m_addr} !== {1'b1, 16'h0008}) begin miscompares++; $display("FAIL wrap_addr: got %h want %h", {m_en, m_addr}, {1'b1, 16'h0008}); end
        repeat (LAT) @(negedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({i_rvalid, i_rdata} !== {1'b1, 32'h1234_5678}) begin
            miscompares++; $display("FAIL wrap_resp: got %h want %h", {i_rvalid, i_rdata}, {1'b1, 32'h1234_5678});
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h0000_2002; d_wdata = 32'hDEAD_BEEF; #1;
        vectors++;
        if ({i_gnt, d_gnt} !== 2'b01) begin miscompares++; $display("FAIL store_gnt: got %b want 01", {i_gnt, d_gnt}); end
        @(negedge clk); d_req = 1'b0; #1;
        vectors++;
        if ({m_en, m_we, m_wstrb, m_addr, m_wdata} !== {1'b1, 1'b1, 4'b0011, 16'h2000, 32'hDEAD_BEEF}) begin
            miscompares++; $display("FAIL store_issue: got %h want %h", {m_en, m_we, m_wstrb, m_addr, m_wdata},
                                    {1'b1, 1'b1, 4'b0011, 16'h2000, 32'hDEAD_BEEF});
        end
        repeat (LAT) begin
            @(negedge clk); #1;
            vectors++;
            if ({m_en, m_we, m_wstrb, d_rvalid} !== 7'd0) begin
                miscompares++; $display("FAIL store_wait: got %b want 0", {m_en, m_we, m_wstrb, d_rvalid});
            end
        end
        @(negedge clk); #1;
        vectors++;
        if ({d_rvalid, i_rvalid, d_rdata} !== {2'b10, 32'd0}) begin
            miscompares++; $display("FAIL store_resp: got %h want %h", {d_rvalid, i_rvalid, d_rdata}, {2'b10, 32'd0});
        end
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_wstrb = 4'b0000; d_addr = 32'h0000_2000; d_wdata = 32'd0; #1;
        vectors++;
        if ({i_gnt, d_gnt} !== 2'b01) begin miscompares++; $display("FAIL load_gnt: got %b want 01", {i_gnt, d_gnt}); end
        @(negedge clk); d_req = 1'b0; #1;
        vectors++;
        if ({m_en, m_we, m_wstrb} !== 6'b100000) begin miscompares++; $display("FAIL load_issue: got %b want 100000", {m_en, m_we, m_wstrb}); end
        repeat (LAT) @(negedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h0000_BEEF}) begin
            miscompares++; $display("FAIL load_resp: got %h want %h", {d_rvalid, d_rdata}, {1'b1, 32'h0000_BEEF});
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; i_req = 1'b1; i_addr = 32'h0000_0004; #1;
        vectors++;
        if ({i_gnt, d_gnt} !== 2'b01) begin miscompares++; $display("FAIL coll_gnt: got %b want 01", {i_gnt, d_gnt}); end
        @(negedge clk); d_req = 1'b0; #1;
        vectors++;
        if ({m_en, i_gnt, d_gnt} !== 3'b100) begin miscompares++; $display("FAIL coll_issue: got %b want 100", {m_en, i_gnt, d_gnt}); end
        repeat (LAT) begin
            @(negedge clk); #1;
            vectors++;
            if (i_gnt !== 1'b0) begin miscompares++; $display("FAIL coll_wait_gnt: got %b want 0", i_gnt); end
        end
        @(negedge clk); #1;
        vectors++;
        if ({d_rvalid, i_gnt, d_rdata} !== {2'b10, 32'h0000_BEEF}) begin
            miscompares++; $display("FAIL coll_resp: got %h want %h", {d_rvalid, i_gnt, d_rdata}, {2'b10, 32'h0000_BEEF});
        end
        @(negedge clk); #1;
        vectors++;
        if ({i_gnt, d_gnt} !== 2'b10) begin miscompares++; $display("FAIL coll_i_gnt: got %b want 10", {i_gnt, d_gnt}); end
        @(negedge clk); i_req = 1'b0; #1;
        vectors++;
        if ({m_en, m_addr} !== {1'b1, 16'h0004}) begin miscompares++; $display("FAIL coll_i_issue: got %h want %h", {m_en, m_addr}, {1'b1, 16'h0004}); end
        repeat (LAT) @(negedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({i_rvalid, i_rdata} !== {1'b1, 32'h0000_0093}) begin
            miscompares++; $display("FAIL coll_i_resp: got %h want %h", {i_rvalid, i_rdata}, {1'b1, 32'h0000_0093});
        end
    endtask

    task automatic test_starvation();
        logic [9:0] exp_i;
        exp_i = 10'b1000010000;  // bit g set where grant g (from LSB) must go to I
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        for (int g = 0; g < 10; g++) begin
            #1;
            vectors++;
            if ({i_gnt, d_gnt} !== (exp_i[g] ? 2'b10 : 2'b01)) begin
                miscompares++; $display("FAIL streak_gnt%0d: got %b want %b", g, {i_gnt, d_gnt}, exp_i[g] ? 2'b10 : 2'b01);
            end
            if (g < 9) repeat (LAT + 3) @(negedge clk);
        end
        @(negedge clk); i_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; #1;
        vectors++;
        if ({i_gnt, d_gnt} !== 2'b01) begin miscompares++; $display("FAIL rmid_gnt: got %b want 01", {i_gnt, d_gnt}); end
        @(negedge clk); d_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we, m_wstrb, m_addr, m_wdata} !== '0) begin
            miscompares++;
            $display("FAIL rmid_outputs: got %h want 0",
                     {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we, m_wstrb, m_addr, m_wdata});
        end
        rst = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk); #1;
            vectors++;
            if ({d_rvalid, m_en} !== 2'b00) begin miscompares++; $display("FAIL rmid_no_rvalid: got %b want 00", {d_rvalid, m_en}); end
        end
        @(negedge clk); i_req = 1'b1; i_addr = 32'h0000_0004; #1;
        vectors++;
        if ({i_gnt, d_gnt} !== 2'b10) begin miscompares++; $display("FAIL rmid_fetch_gnt: got %b want 10", {i_gnt, d_gnt}); end
        @(negedge clk); i_req = 1'b0; #1;
        vectors++;
        if ({m_en, m_addr} !== {1'b1, 16'h0004}) begin miscompares++; $display("FAIL rmid_fetch_issue: got %h want %h", {m_en, m_addr}, {1'b1, 16'h0004}); end
        repeat (LAT) @(negedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({i_rvalid, i_rdata} !== {1'b1, 32'h0000_0093}) begin
            miscompares++; $display("FAIL rmid_fetch_resp: got %h want %h", {i_rvalid, i_rdata}, {1'b1, 32'h0000_0093});
        end
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
        test_reset();
        test_single_fetch();
        test_addr_wrap();
        test_store_load();
        test_collision();
        test_starvation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
